// File: rtl/game_pkg.sv
// Shared game datapath definitions: widths, collision FSM encodings,
// datapath op codes and a small popcount helper.
package game_pkg;

  localparam int N_ENEMY = 3;
  localparam int COORD_W = 10;
  localparam int RAD_W   = 6;

  // Derived datapath widths
  localparam int SUM_W = RAD_W + 1;     // r + ENEMY_R
  localparam int THR_W = 2 * SUM_W;     // (r + ENEMY_R)^2
  localparam int SQ_W  = 2 * COORD_W;   // |d|^2
  localparam int ACC_W = SQ_W + 1;      // dx^2 + dy^2

  // Collision FSM state encodings
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_RAD  = 3'd1;
  localparam logic [2:0] ST_DX   = 3'd2;
  localparam logic [2:0] ST_DY   = 3'd3;
  localparam logic [2:0] ST_CMP  = 3'd4;
  localparam logic [2:0] ST_DONE = 3'd5;

  // What the shared square unit does with its product this cycle
  typedef enum logic [1:0] {
    OP_NONE = 2'd0,
    OP_THR  = 2'd1,   // product -> thr
    OP_LOAD = 2'd2,   // product -> acc
    OP_ADD  = 2'd3    // acc + product -> acc
  } sq_op_t;

  function automatic logic [1:0] popcount3(input logic [N_ENEMY-1:0] v);
    logic [1:0] c;
    c = '0;
    for (int i = 0; i < N_ENEMY; i++) c = c + {1'b0, v[i]};
    return c;
  endfunction

endpackage

// File: rtl/sq_dist_unit.sv
// Shared abs-diff / square / accumulate datapath. A single multiplier
// squares either the radius sum or |a - b|, selected by op.
module sq_dist_unit
  import game_pkg::*;
#(
  parameter int ENEMY_R = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  sq_op_t             op,
  input  logic [COORD_W-1:0] a,
  input  logic [COORD_W-1:0] b,
  input  logic [RAD_W-1:0]   r,
  output logic [ACC_W-1:0]   acc,
  output logic [THR_W-1:0]   thr
);

  localparam logic [SUM_W-1:0] ENEMY_R_V = SUM_W'(ENEMY_R);

  logic [SUM_W-1:0]   rad_sum;
  logic [COORD_W-1:0] abs_diff;
  logic [COORD_W-1:0] mul_op;
  logic [SQ_W-1:0]    sq;

  // Operand select feeding the one shared squarer
  always_comb begin
    rad_sum  = {1'b0, r} + ENEMY_R_V;
    abs_diff = (a >= b) ? (a - b) : (b - a);
    mul_op   = (op == OP_THR) ? {{(COORD_W-SUM_W){1'b0}}, rad_sum} : abs_diff;
    sq       = SQ_W'(mul_op) * SQ_W'(mul_op);
  end

  // Threshold / accumulator registers; max 2*1023^2 fits ACC_W
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc <= '0;
      thr <= '0;
    end else begin
      case (op)
        OP_THR:  thr <= sq[THR_W-1:0];
        OP_LOAD: acc <= {1'b0, sq};
        OP_ADD:  acc <= acc + {1'b0, sq};
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/collision_scheduler.sv
// Per-frame player-vs-enemy circle collision controller. Steps one shared
// squared-distance unit through radius, dx, dy and compare for each enemy,
// then publishes a hit vector and updates a saturating score.
module collision_scheduler
  import game_pkg::*;
#(
  parameter int ENEMY_R = 8,
  parameter int SCORE_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               frame_tick,
  input  logic               gamemenu,
  input  logic               gamerun,
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  input  logic [RAD_W-1:0]   r,
  input  logic [COORD_W-1:0] E1x,
  input  logic [COORD_W-1:0] E1y,
  input  logic [COORD_W-1:0] E2x,
  input  logic [COORD_W-1:0] E2y,
  input  logic [COORD_W-1:0] E3x,
  input  logic [COORD_W-1:0] E3y,
  output logic               busy,
  output logic [N_ENEMY-1:0] hit,
  output logic               hit_valid,
  output logic [SCORE_W-1:0] score,
  output logic               overrun
);

  localparam logic [SCORE_W+1:0] SCORE_MAX = {2'b00, {SCORE_W{1'b1}}};

  logic [2:0]                       state;
  logic [1:0]                       idx;
  logic [N_ENEMY-1:0]               hit_r;
  logic [COORD_W-1:0]               x_s, y_s;
  logic [RAD_W-1:0]                 r_s;
  logic [N_ENEMY-1:0][COORD_W-1:0]  ex_s, ey_s;

  sq_op_t             op;
  logic [COORD_W-1:0] op_a, op_b;
  logic [ACC_W-1:0]   acc;
  logic [THR_W-1:0]   thr;
  logic               start;
  logic               in_range;
  logic [SCORE_W+1:0] score_sum;
  logic [SCORE_W-1:0] score_nxt;

  sq_dist_unit #(.ENEMY_R(ENEMY_R)) u_sq (
    .clk   (clk),
    .reset (reset),
    .op    (op),
    .a     (op_a),
    .b     (op_b),
    .r     (r_s),
    .acc   (acc),
    .thr   (thr)
  );

  // Datapath op and operand select by FSM state; compare and score math
  always_comb begin
    start = (state == ST_IDLE) && frame_tick && gamerun;
    op    = OP_NONE;
    op_a  = x_s;
    op_b  = ex_s[idx];
    case (state)
      ST_RAD: op = OP_THR;
      ST_DX:  op = OP_LOAD;
      ST_DY: begin
        op   = OP_ADD;
        op_a = y_s;
        op_b = ey_s[idx];
      end
      default: ;
    endcase
    in_range  = (acc <= ACC_W'(thr));   // touching counts as a hit
    score_sum = {2'b00, score} + (SCORE_W+2)'(popcount3(hit_r));
    score_nxt = (score_sum > SCORE_MAX) ? SCORE_MAX[SCORE_W-1:0]
                                        : score_sum[SCORE_W-1:0];
  end

  // Freeze the frame's inputs when a check sequence starts
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_s  <= '0;
      y_s  <= '0;
      r_s  <= '0;
      ex_s <= '0;
      ey_s <= '0;
    end else if (start) begin
      x_s  <= x;
      y_s  <= y;
      r_s  <= r;
      ex_s <= {E3x, E2x, E1x};
      ey_s <= {E3y, E2y, E1y};
    end
  end

  // Check sequencer: RAD, then DX/DY/CMP per enemy, then DONE; gamerun low aborts
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      idx       <= '0;
      busy      <= 1'b0;
      hit_r     <= '0;
      hit       <= '0;
      hit_valid <= 1'b0;
    end else begin
      hit_valid <= 1'b0;
      if (state != ST_IDLE && !gamerun) begin
        state <= ST_IDLE;
        idx   <= '0;
        busy  <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: if (start) begin
            state <= ST_RAD;
            busy  <= 1'b1;
          end
          ST_RAD: begin
            idx   <= '0;
            hit_r <= '0;
            state <= ST_DX;
          end
          ST_DX: state <= ST_DY;
          ST_DY: state <= ST_CMP;
          ST_CMP: begin
            hit_r[idx] <= in_range;
            if (idx == 2'(N_ENEMY - 1)) begin
              state <= ST_DONE;
            end else begin
              idx   <= idx + 2'd1;
              state <= ST_DX;
            end
          end
          ST_DONE: begin
            hit       <= hit_r;
            hit_valid <= 1'b1;
            busy      <= 1'b0;
            state     <= ST_IDLE;
          end
          default: begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  // Saturating score; menu clears it
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      score <= '0;
    else if (gamemenu)
      score <= '0;
    else if (state == ST_DONE && gamerun)
      score <= score_nxt;
  end

  // Sticky flag for a frame tick that landed while a sequence was in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      overrun <= 1'b0;
    else if (gamemenu)
      overrun <= 1'b0;
    else if (frame_tick && busy)
      overrun <= 1'b1;
  end

endmodule

// File: tb/tb_collision_scheduler.sv
// Scoreboard bench for collision_scheduler: frames are issued with random or
// directed geometry, expected hit/score pushed at issue, checked on hit_valid.
module tb_collision_scheduler;

  localparam int ENEMY_R = 8;
  localparam int SCORE_W = 8;
  localparam int SMAX    = 255;

  logic       clk = 1'b0;
  logic       reset, frame_tick, gamemenu, gamerun;
  logic [9:0] x, y, E1x, E1y, E2x, E2y, E3x, E3y;
  logic [5:0] r;
  logic       busy, hit_valid, overrun;
  logic [2:0] hit;
  logic [SCORE_W-1:0] score;

  collision_scheduler #(.ENEMY_R(ENEMY_R), .SCORE_W(SCORE_W)) dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .gamemenu(gamemenu),
    .gamerun(gamerun), .x(x), .y(y), .r(r),
    .E1x(E1x), .E1y(E1y), .E2x(E2x), .E2y(E2y), .E3x(E3x), .E3y(E3y),
    .busy(busy), .hit(hit), .hit_valid(hit_valid), .score(score), .overrun(overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] hit;
    logic [7:0] score;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0, n_err = 0, hv_count = 0, model_score = 0;
  int   px, py, pr;
  int   ex[3], ey[3];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply();
    x = 10'(px); y = 10'(py); r = 6'(pr);
    E1x = 10'(ex[0]); E1y = 10'(ey[0]);
    E2x = 10'(ex[1]); E2y = 10'(ey[1]);
    E3x = 10'(ex[2]); E3y = 10'(ey[2]);
  endtask

  // Circle overlap by plain geometry: centre distance^2 <= (r + R)^2
  function automatic logic [2:0] model_hits();
    logic [2:0] h;
    int t;
    t = (pr + ENEMY_R) * (pr + ENEMY_R);
    for (int i = 0; i < 3; i++) begin
      int dx, dy;
      dx = px - ex[i];
      dy = py - ey[i];
      h[i] = (dx * dx + dy * dy) <= t;
    end
    return h;
  endfunction

  task automatic push_expected();
    exp_t e;
    e.hit = model_hits();
    model_score = model_score + $countones(e.hit);
    if (model_score > SMAX) model_score = SMAX;
    e.score = 8'(model_score);
    sb.push_back(e);
  endtask

  function automatic int clamp(input int v);
    return (v < 0) ? 0 : (v > 1023) ? 1023 : v;
  endfunction

  task automatic set_all_overlap(input int c);
    px = c; py = c; pr = 20;
    for (int i = 0; i < 3; i++) begin ex[i] = c + 5 + i; ey[i] = c - 3; end
  endtask

  // One full frame; extra_tick > 0 re-pulses frame_tick on that edge
  task automatic run_frame(input int extra_tick);
    int n;
    apply();
    frame_tick = 1'b1;
    step();                       // edge 0
    frame_tick = 1'b0;
    push_expected();
    // scramble live inputs: the frame in flight must use its snapshot
    x = 10'($urandom); y = 10'($urandom); r = 6'($urandom);
    E1x = 10'($urandom); E2y = 10'($urandom); E3x = 10'($urandom);
    n = 0;
    while (n < 30) begin
      n++;
      if (n <= 11) check("busy_in_flight", busy, 1);
      if (n == extra_tick) frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      if (hit_valid) break;
    end
    check("latency", n, 11);
    check("busy_after_done", busy, 0);
    step();
    check("hit_valid_one_cycle", hit_valid, 0);
  endtask

  // Monitor: every hit_valid pulse is checked against the scoreboard head
  always @(negedge clk) begin
    if (reset === 1'b0 && hit_valid === 1'b1) begin
      hv_count++;
      if (sb.size() == 0) begin
        check("unexpected_hit_valid", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("hit", hit, e.hit);
        check("score", score, e.score);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int hv0;
    reset = 1'b1; frame_tick = 0; gamemenu = 0; gamerun = 0;
    px = 0; py = 0; pr = 0;
    for (int i = 0; i < 3; i++) begin ex[i] = 0; ey[i] = 0; end
    apply();
    repeat (2) step();
    check("rst_busy", busy, 0);
    check("rst_hit", hit, 0);
    check("rst_hit_valid", hit_valid, 0);
    check("rst_score", score, 0);
    check("rst_overrun", overrun, 0);
    reset = 1'b0;
    step();
    gamerun = 1'b1;

    // overlap on enemy 2 only
    px = 100; py = 100; pr = 10;
    ex = '{400, 110, 0}; ey = '{400, 110, 0};
    run_frame(0);
    check("e2_hit", hit, 3'b010);
    check("e2_score", score, 1);

    // touching boundary: 18^2 == (10+8)^2
    px = 200; py = 200; pr = 10;
    ex = '{218, 600, 600}; ey = '{200, 600, 600};
    run_frame(0);
    check("touch_hit", hit[0], 1);
    ex[0] = 219;
    run_frame(0);
    check("just_out_hit", hit[0], 0);

    // extremes: max distance and coincident centres
    px = 0; py = 0; pr = 63;
    ex = '{1023, 0, 1023}; ey = '{1023, 0, 0};
    run_frame(0);

    // random geometry clustered near the player for a mix of hits
    repeat (20) begin
      px = $urandom_range(0, 1023); py = $urandom_range(0, 1023);
      pr = $urandom_range(0, 63);
      for (int i = 0; i < 3; i++) begin
        ex[i] = clamp(px + $urandom_range(0, 160) - 80);
        ey[i] = clamp(py + $urandom_range(0, 160) - 80);
      end
      run_frame(0);
    end

    // overrun: second tick 5 edges in is ignored
    hv0 = hv_count;
    run_frame(5);
    check("overrun_set", overrun, 1);
    check("overrun_one_pulse", hv_count - hv0, 1);
    gamerun = 1'b0; gamemenu = 1'b1;
    step();
    gamemenu = 1'b0;
    model_score = 0;
    check("menu_overrun", overrun, 0);
    check("menu_score", score, 0);
    gamerun = 1'b1;

    set_all_overlap(300);
    run_frame(0);

    // abort: gamerun dropped before edge 6
    set_all_overlap(500);
    apply();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    repeat (5) step();
    gamerun = 1'b0;
    step();
    check("abort_busy", busy, 0);
    hv0 = hv_count;
    repeat (15) step();
    check("abort_no_pulse", hv_count - hv0, 0);
    check("abort_score", score, 32'(model_score));
    gamerun = 1'b1;

    // saturation
    set_all_overlap(700);
    repeat (90) run_frame(0);
    check("sat_score", score, SMAX);

    // async reset mid-sequence, with overrun set and score nonzero
    apply();
    frame_tick = 1'b1;
    step();                   // edge 0
    frame_tick = 1'b0;
    step();                   // edge 1
    frame_tick = 1'b1;
    step();                   // edge 2: overrun
    frame_tick = 1'b0;
    step();                   // edge 3
    step();                   // edge 4
    check("pre_rst_overrun", overrun, 1);
    check("pre_rst_busy", busy, 1);
    #2 reset = 1'b1;
    #1;
    check("arst_busy", busy, 0);
    check("arst_hit_valid", hit_valid, 0);
    check("arst_score", score, 0);
    check("arst_overrun", overrun, 0);
    step();
    reset = 1'b0;
    model_score = 0;
    step();

    px = 50; py = 60; pr = 5;
    ex = '{55, 900, 58}; ey = '{60, 900, 70};
    run_frame(0);
    repeat (3) step();
    check("scoreboard_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/collision_scheduler.md
Name: collision_scheduler

Overview:
- Per-frame collision controller for the game datapath.
- Once per frame it checks the player circle against each of the 3 enemies.
- All checks share one squared-distance multiplier, stepped through by an FSM.
- It emits a hit vector and keeps the score. It sits between the position blocks (player_position, enemy_position1..3, radius) and the gamestate / circle_gen consumers, clocked on clk_d.

Parameters:
- ENEMY_R, 8: enemy radius in pixels. Range 1..63.
- SCORE_W, 8: score counter width.

Ports:
- clk  in  1  pixel clock (clk_d domain)
- reset  in  1  asynchronous, active-high reset
- frame_tick  in  1  one-cycle pulse at frame start
- gamemenu  in  1  menu state (clears score)
- gamerun  in  1  run state (enables checks)
- x  in  10  player centre x
- y  in  10  player centre y
- r  in  6  player radius
- E1x, E1y, E2x, E2y, E3x, E3y  in  10 each  enemy centres
- busy  out  1  high while a check sequence is in flight
- hit  out  3  bit i = player overlaps enemy i+1; valid with hit_valid
- hit_valid  out  1  one-cycle pulse, result of one frame
- score  out  SCORE_W  accumulated hit count, saturating
- overrun  out  1  sticky; frame_tick arrived while busy

Behaviour:
- Reset (async, active-high) values:
  - FSM = IDLE, idx = 0.
  - busy = 0, hit = 0, hit_valid = 0, score = 0, overrun = 0.
  - acc = 0, thr = 0.
- FSM states: IDLE, RAD, DX, DY, CMP, DONE. Each state lasts exactly one cycle.
- IDLE:
  - If frame_tick & gamerun: go to RAD, busy <= 1.
  - Snapshot x, y, r and all six enemy coordinates into local registers. Later input changes do not affect the frame in flight.
- RAD: thr <= (r + ENEMY_R)^2, computed on the shared multiplier. 7-bit sum, 14-bit product. idx <= 0. Go to DX.
- DX: acc <= |x - Ex[idx]|^2. The abs difference is 10 bits, the square 20 bits. Go to DY.
- DY: acc <= acc + |y - Ey[idx]|^2. The sum is 21 bits. Go to CMP.
- CMP:
  - hit_r[idx] <= (acc <= thr). Touching counts as a hit.
  - If idx == 2, go to DONE. Otherwise idx++ and go to DX.
- DONE:
  - hit <= hit_r and hit_valid <= 1, for one cycle.
  - score <= min(score + popcount(hit_r), 2^SCORE_W - 1).
  - busy <= 0. Go to IDLE.
- Multiplier: exactly one multiplier instance; operands are muxed by state. No other multiplies exist.
- Latency:
  - The edge that samples frame_tick is edge 0.
  - hit_valid is high in the cycle following edge 11.
  - busy is high from edge 0 through edge 11.
- Boundary conditions:
  - frame_tick while busy: ignored, overrun <= 1. overrun is cleared only by reset or gamemenu.
  - gamerun falls mid-sequence (pause or escape): abort to IDLE on the next edge. busy <= 0, no hit_valid, score unchanged.
  - gamemenu high: score <= 0 and overrun <= 0 every cycle. Checks do not start, since gamerun is low.
  - frame_tick & gamerun on the same edge that DONE returns to IDLE: not sampled. The next tick is required.
  - Score saturates at 255 and never wraps.
  - Coordinates equal (dx = dy = 0): hit.
  - Max distance: 1023^2 + 1023^2 fits in 21 bits, so there is no overflow.
- hit holds its last value between pulses. Consumers sample it only when hit_valid is high.

Decomposition:
- Shared package game_pkg holds:
  - N_ENEMY = 3.
  - COORD_W = 10, RAD_W = 6.
  - State encodings for this FSM.
- One natural sub-module: sq_dist_unit, the shared abs-diff, square and accumulate datapath. Operand select comes from the FSM.
- The FSM and score logic stay in collision_scheduler.

Test Plan:
- Overlap on enemy 2 only:
  - Stimulus: reset, gamerun = 1, x = y = 100, r = 10, E2 = (110, 110), E1 = (400, 400), E3 = (0, 0); pulse frame_tick.
  - Required: at edge 11, hit = 3'b010, hit_valid = 1 for one cycle, score = 1.
- Touching boundary, ENEMY_R = 8:
  - Stimulus: r = 10, player (200, 200), E1 = (218, 200).
  - Required: dist² 324 == thr 324 → hit[0] = 1. With E1 = (219, 200), dist² 361 → hit[0] = 0.
- Overrun:
  - Stimulus: a second frame_tick 5 cycles after the first.
  - Required: ignored, overrun = 1, exactly one hit_valid.
  - Then gamemenu pulse → overrun = 0, score = 0.
- Abort:
  - Stimulus: drop gamerun at edge 6 with all three enemies overlapping.
  - Required: busy = 0 by edge 7, no hit_valid, score unchanged.
- Saturation:
  - Stimulus: all three enemies overlapping, 90 frames.
  - Required: score reaches 255 and stays 255.
- Async reset:
  - Stimulus: assert reset mid-sequence (edge 4), between clock edges.
  - Required: busy, hit_valid, score and overrun go to 0 immediately, before the next edge.
